// File: rtl/codec_serializer.sv
// codec_serializer: sample FIFO feeding a mono-duplicated I2S-style serializer.
// Optional macro UNDERFLOW_CNT_EN adds a saturating underflow counter port.
module codec_serializer #(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_sample_in,
  input  logic        i_sample_valid,
  output logic        o_sample_ready,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_dacdat,
  output logic        o_underflow
`ifdef UNDERFLOW_CNT_EN
  ,
  output logic [7:0]  o_underflow_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  state_t      r_state;
  logic [7:0]  r_div;
  logic [4:0]  r_bit;
  logic [15:0] r_hold;
  logic [15:0] r_shift;
  logic        r_bclk;
  logic        r_lrclk;
  logic        r_dacdat;
  logic        r_uf;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_fall;
  logic        w_wrap;
  logic        w_load;
  logic        w_pop;
  logic [15:0] w_word;
  logic [4:0]  w_next;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = i_sample_valid && !w_full;
  assign w_fall  = (r_state == S_RUN) &&
                   (r_div == 8'(DIV - 1)) && r_bclk;
  assign w_wrap  = w_fall && (r_bit == 5'd31);
  // Enable is only looked at in IDLE or on the frame-wrap edge.
  assign w_load  = i_enable &&
                   ((r_state == S_IDLE) || w_wrap);
  assign w_pop   = w_load && !w_empty;
  // An empty FIFO at load time sends silence; a same-cycle push waits.
  assign w_word  = w_empty ? 16'h0000 : r_mem[r_rp];
  assign w_next  = r_bit + 5'd1;

  assign o_sample_ready = !w_full;
  assign o_bclk         = r_bclk;
  assign o_lrclk        = r_lrclk;
  assign o_dacdat       = r_dacdat;
  assign o_underflow    = r_uf;

  // FIFO storage write; contents are don't-care once pointers reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset)
      r_mem[r_wp] <= i_sample_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  // Serializer FSM: bit clock divider, bit counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_hold   <= '0;
      r_shift  <= '0;
      r_bclk   <= 1'b0;
      r_lrclk  <= 1'b0;
      r_dacdat <= 1'b0;
      r_uf     <= 1'b0;
    end else begin
      r_uf <= 1'b0;
      if (w_load) begin
        r_state  <= S_RUN;
        r_hold   <= w_word;
        r_shift  <= w_word;
        r_dacdat <= w_word[15];
        r_lrclk  <= 1'b0;
        r_bclk   <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        r_uf     <= w_empty;
      end else if (r_state == S_RUN) begin
        if (r_div == 8'(DIV - 1)) begin
          r_div  <= '0;
          r_bclk <= ~r_bclk;
          if (r_bclk) begin
            if (r_bit == 5'd31) begin
              r_state  <= S_IDLE;
              r_bit    <= '0;
              r_lrclk  <= 1'b0;
              r_dacdat <= 1'b0;
            end else begin
              r_bit   <= w_next;
              r_lrclk <= w_next[4];
              // Right channel restarts the same word from its MSB.
              if (w_next[3:0] == 4'd0) begin
                r_shift  <= r_hold;
                r_dacdat <= r_hold[15];
              end else begin
                r_shift  <= {r_shift[14:0], 1'b0};
                r_dacdat <= r_shift[14];
              end
            end
          end
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

`ifdef UNDERFLOW_CNT_EN
  logic [7:0] r_ucnt;

  assign o_underflow_count = r_ucnt;

  // Saturating count of frames loaded from an empty FIFO.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_ucnt <= '0;
    else if (w_load && w_empty && r_ucnt != 8'hFF)
      r_ucnt <= r_ucnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_codec_serializer.sv
// tb_codec_serializer: randomized bench against a frame-timeline model.
// Model works from time-since-frame-load and a sample queue.
module tb_codec_serializer;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 64 * DIV;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic        vld;
  logic        rdy;
  logic        bclk;
  logic        lrclk;
  logic        dat;
  logic        uf;
`ifdef UNDERFLOW_CNT_EN
  logic [7:0]  ucnt;
`endif

  codec_serializer #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_sample_in    (din),
    .i_sample_valid (vld),
    .o_sample_ready (rdy),
    .o_bclk         (bclk),
    .o_lrclk        (lrclk),
    .o_dacdat       (dat),
    .o_underflow    (uf)
`ifdef UNDERFLOW_CNT_EN
    ,
    .o_underflow_count (ucnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q [$];
  bit          m_run  = 0;
  int          m_t    = 0;
  logic [15:0] m_word = '0;
  bit          m_uf   = 0;
  int          m_ucnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    int   b;
    logic e_bclk;
    logic e_lr;
    logic e_dat;
    e_bclk = 0;
    e_lr   = 0;
    e_dat  = 0;
    if (m_run) begin
      b      = m_t / (2 * DIV);
      e_bclk = (m_t % (2 * DIV)) >= DIV;
      e_lr   = (b >= 16);
      e_dat  = m_word[15 - (b % 16)];
    end
    chk("ready", 32'(rdy), 32'(q.size() < DEPTH));
    chk("bclk", 32'(bclk), 32'(e_bclk));
    chk("lrclk", 32'(lrclk), 32'(e_lr));
    chk("dacdat", 32'(dat), 32'(e_dat));
    chk("underflow", 32'(uf), 32'(m_uf));
`ifdef UNDERFLOW_CNT_EN
    chk("ucount", 32'(ucnt), 32'(m_ucnt));
`endif
  endtask

  task automatic model_edge(input logic r, input logic e,
                            input logic v,
                            input logic [15:0] d);
    bit full_pre;
    bit load;
    if (r) begin
      q.delete();
      m_run  = 0;
      m_t    = 0;
      m_word = '0;
      m_uf   = 0;
      m_ucnt = 0;
      return;
    end
    full_pre = (q.size() == DEPTH);
    load     = 0;
    m_uf     = 0;
    if (!m_run) begin
      if (e) begin
        load  = 1;
        m_run = 1;
      end
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        if (e) load = 1;
        else m_run = 0;
      end
    end
    if (load) begin
      m_t = 0;
      if (q.size() > 0) begin
        m_word = q.pop_front();
      end else begin
        m_word = 16'h0000;
        m_uf   = 1;
        if (m_ucnt < 255) m_ucnt++;
      end
    end
    if (v && !full_pre) q.push_back(d);
  endtask

  // One clock: check previous edge's results, drive, model the edge.
  task automatic cyc(input logic r, input logic e,
                     input logic v,
                     input logic [15:0] d);
    @(negedge clk);
    check_outs();
    rst = r;
    en  = e;
    vld = v;
    din = d;
    @(posedge clk);
    model_edge(r, e, v, d);
  endtask

  task automatic idle_n(input int n, input logic e);
    for (int i = 0; i < n; i++) cyc(0, e, 0, 16'h0);
  endtask

  initial begin
    rst = 1;
    en  = 0;
    vld = 0;
    din = '0;
    cyc(1, 0, 0, 16'h0);
    cyc(1, 1, 1, 16'hFFFF);
    idle_n(2, 0);

    // Single word, one full frame, then back to IDLE.
    cyc(0, 0, 1, 16'hA5C3);
    idle_n(FRAME + 1, 1);
    idle_n(FRAME + 4, 0);

    // Overfill in IDLE, then four frames drain it.
    for (int i = 1; i <= 5; i++)
      cyc(0, 0, 1, 16'(i * 16'h1111));
    idle_n(4 * FRAME + 2, 1);
    idle_n(FRAME + 4, 0);

    // Push in the exact load cycle with an empty FIFO.
    cyc(0, 1, 1, 16'h7FFF);
    idle_n(2 * FRAME, 1);

    // Drop Enable early in a frame; queued words must survive.
    cyc(0, 1, 1, 16'h1234);
    cyc(0, 1, 1, 16'h5678);
    idle_n(FRAME - 3, 1);
    idle_n(5 * 2 * DIV, 1);
    idle_n(FRAME + 10, 0);

    // Reset mid-frame with samples queued.
    cyc(0, 0, 1, 16'hBEEF);
    idle_n(20 * 2 * DIV + 3, 1);
    cyc(1, 1, 1, 16'hCAFE);
    @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_dat", 32'(dat), 32'd0);
    idle_n(3, 0);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      int len;
      int pv;
      int pe;
      len = $urandom_range(50, 700);
      pv  = $urandom_range(0, 100);
      pe  = $urandom_range(0, 100);
      for (int i = 0; i < len; i++) begin
        logic r;
        r = ($urandom_range(0, 999) == 0);
        cyc(r, ($urandom_range(0, 99) < pe),
            ($urandom_range(0, 99) < pv),
            16'($urandom));
      end
    end

    @(negedge clk);
    check_outs();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/codec_serializer.md
CODEC_SERIALIZER -- requirements
Module: codec_serializer

Interface
REQ-001 SHALL have parameter DIV, default 4: the number of Clk cycles per bclk half-period (range 2..255).
REQ-002 SHALL have parameter DEPTH, default 4: the number of sample FIFO entries (a power of two, range 2..16).
REQ-003 Clk  input  1  system clock; the single clock, and all logic is on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Enable  input  1  run request; sampled only in IDLE and at frame boundaries.
REQ-006 sample_in  input  16  two's-complement filtered sample from the upstream filter stage (its y output).
REQ-007 sample_valid  input  1  sample_in is valid this cycle.
REQ-008 sample_ready  output  1  FIFO can accept a sample; equals !full.
REQ-009 bclk  output  1  codec bit clock.
REQ-010 lrclk  output  1  channel select; 0 = left, 1 = right.
REQ-011 dacdat  output  1  serial data, MSB first.
REQ-012 underflow  output  1  one-Clk pulse for each frame loaded from an empty FIFO.
REQ-013 underflow_count  output  8  saturating underflow counter; present only with UNDERFLOW_CNT_EN.

Function
REQ-014 SHALL accept a push when sample_valid && sample_ready, and store sample_in unchanged at the FIFO tail.
REQ-015 SHALL ignore sample_valid while full; no overwrite and no error flag.
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 IDLE: bclk=0, lrclk=0, dacdat=0, divider and bit counter held at 0; FIFO continues to accept pushes.
REQ-018 IDLE->RUN: in the cycle after Enable is seen high in IDLE, perform a frame load and set dacdat=word[15], lrclk=0, bclk=0.
REQ-019 Frame load: pop the FIFO head into a 16-bit hold register and the shift register; if the FIFO is empty, load 0x0000 and assert underflow for that cycle.
REQ-020 Divider counts 0..DIV-1 and toggles bclk on reaching DIV-1, so the bclk period is 2*DIV Clk cycles.
REQ-021 Each bclk falling edge SHALL advance the 5-bit bit counter (0..31) and update dacdat and lrclk in the same cycle; dacdat is therefore stable across the rising edge.
REQ-022 Bits 0..15: lrclk=0, shift out the hold word MSB first. Bits 16..31: lrclk=1, retransmit the same hold word MSB first (mono duplicated on both channels).
REQ-023 On the falling edge where the bit counter wraps 31->0: if Enable=1, perform a frame load; if Enable=0, enter IDLE with IDLE outputs next cycle.
REQ-024 A simultaneous push and frame load on an empty FIFO SHALL signal underflow and load 0x0000; the pushed sample is retained for the next frame.
REQ-025 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the occupancy unchanged.
REQ-026 Latency: a sample pushed into an empty FIFO before a frame load appears on dacdat in that load cycle; otherwise at the next frame boundary.
REQ-027 Frame length SHALL be 64*DIV Clk cycles, giving exactly one FIFO pop per frame.

Reset
REQ-028 Reset SHALL override all other inputs and, on the next Clk edge, set: FSM=IDLE, FIFO empty, sample_ready=1, bclk=0, lrclk=0, dacdat=0, underflow=0, underflow_count=0, divider=0, bit counter=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; FIFO contents are discarded.

Configuration
REQ-030 With macro UNDERFLOW_CNT_EN defined: underflow_count increments on each underflow pulse and saturates at 255, clearing only on Reset.
REQ-031 Without UNDERFLOW_CNT_EN: the underflow_count port and its counter are absent; underflow pulse behaviour is unchanged.

Verification (DIV=4, DEPTH=4)
REQ-032 Push 0xA5C3, then raise Enable -> frame loads 0xA5C3; dacdat over 32 falling edges reads 1010010111000011 twice; lrclk toggles at bit 16; frame is 256 Clk cycles.
REQ-033 Push 5 samples back-to-back while in IDLE -> sample_ready drops after the 4th; the 5th is not stored; the next 4 frames carry samples 1..4.
REQ-034 Enable high with an empty FIFO -> each frame transmits 0x0000 with a one-cycle underflow pulse; with UNDERFLOW_CNT_EN, count reaches 255 after 300 frames and holds.
REQ-035 Push 0x7FFF in the exact frame-load cycle with the FIFO empty -> underflow=1, current frame is 0x0000, next frame is 0x7FFF.
REQ-036 Drop Enable at bit 5 -> the frame completes all 32 bits, then IDLE; bclk, lrclk and dacdat are 0 and remaining FIFO entries are preserved.
REQ-037 Assert Reset at bit 20 with 3 samples queued -> next cycle all outputs are at reset values, sample_ready=1, and the FIFO is empty.
